ram_queue_ctrl: RTL and testbench

RAM_QUEUE_CTRL -- requirements
Module: ram_queue_ctrl

---
 rtl/ram_queue_ctrl.sv | 112 +++++++++++
 tb/tb_ram_queue_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_queue_ctrl.sv
// FIFO controller that keeps its entries in an external single-port RAM.
// Push and pop share the RAM port; contended cycles alternate between the two sides.
module ram_queue_ctrl #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_ready,
    input  logic                  pop_req,
    output logic                  pop_ack,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  ram_write_en,
    output logic                  ram_read_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    typedef enum logic {
        GrantPush = 1'b0,
        GrantPop  = 1'b1
    } grant_e;

    localparam logic [ADDR_WIDTH:0]   DepthCount = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CountOne   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PtrOne     = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    grant_e                last_grant_q, last_grant_d;
    logic                  pop_valid_q, pop_valid_d;

    logic push_cand, pop_cand;
    logic push_win, pop_win;

    assign full      = (count_q == DepthCount);
    assign empty     = (count_q == '0);
    assign push_cand = push_valid && !full;
    assign pop_cand  = pop_req && !empty;

    // Under contention the side that did not win last time gets the RAM port.
    always_comb begin
        push_win = 1'b0;
        pop_win  = 1'b0;
        if (!rst) begin
            if (push_cand && pop_cand) begin
                if (last_grant_q == GrantPop) begin
                    push_win = 1'b1;
                end else begin
                    pop_win = 1'b1;
                end
            end else begin
                push_win = push_cand;
                pop_win  = pop_cand;
            end
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        pop_valid_d  = pop_win;
        if (push_win) begin
            wr_ptr_d     = wr_ptr_q + PtrOne;
            count_d      = count_q + CountOne;
            last_grant_d = GrantPush;
        end else if (pop_win) begin
            rd_ptr_d     = rd_ptr_q + PtrOne;
            count_d      = count_q - CountOne;
            last_grant_d = GrantPop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_grant_q <= GrantPop;
            pop_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            pop_valid_q  <= pop_valid_d;
        end
    end

    assign push_ready   = push_win;
    assign ram_write_en = push_win;
    assign pop_ack      = pop_win;
    assign ram_read_en  = pop_win;
    assign ram_addr     = pop_win ? rd_ptr_q : wr_ptr_q;
    assign ram_data_in  = push_data;

    // RAM read data lines up with pop_valid one cycle after the read strobe.
    assign pop_valid = pop_valid_q;
    assign pop_data  = pop_valid_q ? ram_data_out : '0;
    assign count     = count_q;

endmodule

// File: tb/tb_ram_queue_ctrl.sv
// Directed bench for ram_queue_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_ram_queue_ctrl;

    logic       clk;
    logic       rst;
    logic       push_valid;
    logic [5:0] push_data;
    logic       push_ready;
    logic       pop_req;
    logic       pop_ack;
    logic       pop_valid;
    logic [5:0] pop_data;
    logic       ram_write_en;
    logic       ram_read_en;
    logic [3:0] ram_addr;
    logic [5:0] ram_data_in;
    logic [5:0] ram_data_out;
    logic [4:0] count;
    logic       full;
    logic       empty;

    int checks;
    int failures;

    ram_queue_ctrl #(
        .DATA_WIDTH(6),
        .ADDR_WIDTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (push_valid),
        .push_data   (push_data),
        .push_ready  (push_ready),
        .pop_req     (pop_req),
        .pop_ack     (pop_ack),
        .pop_valid   (pop_valid),
        .pop_data    (pop_data),
        .ram_write_en(ram_write_en),
        .ram_read_en (ram_read_en),
        .ram_addr    (ram_addr),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with one cycle read latency.
    logic [5:0] mem [16];
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_addr] <= ram_data_in;
        if (ram_read_en) ram_data_out <= mem[ram_addr];
    end

    typedef struct {
        logic       rst;
        logic       pv;
        logic [5:0] pd;
        logic       pr;
        logic       e_prdy;
        logic       e_pack;
        logic       e_we;
        logic       e_re;
        logic [3:0] e_addr;
        logic [4:0] e_cnt;
        logic       e_pvld;
        logic [5:0] e_pdata;
    } vec_t;

    vec_t       vecs[12];
    logic [5:0] model_q[$];
    logic [5:0] exp_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic pv, input logic [5:0] pd, input logic pr);
        @(negedge clk);
        rst        = r;
        push_valid = pv;
        push_data  = pd;
        pop_req    = pr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_comb(input string tag, input logic prdy, input logic pack,
                              input logic we, input logic re, input logic [3:0] addr);
        chk({tag, ".push_ready"}, push_ready, prdy);
        chk({tag, ".pop_ack"}, pop_ack, pack);
        chk({tag, ".ram_write_en"}, ram_write_en, we);
        chk({tag, ".ram_read_en"}, ram_read_en, re);
        chk({tag, ".ram_addr"}, ram_addr, addr);
    endtask

    task automatic check_state(input string tag, input logic [4:0] cnt, input logic pvld,
                               input logic [5:0] pdata);
        chk({tag, ".count"}, count, cnt);
        chk({tag, ".empty"}, empty, cnt == 5'd0);
        chk({tag, ".full"}, full, cnt == 5'd16);
        chk({tag, ".pop_valid"}, pop_valid, pvld);
        chk({tag, ".pop_data"}, pop_data, pdata);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        push_valid = 1'b0;
        push_data  = '0;
        pop_req    = 1'b0;

        //            rst   pv    pd     pr    prdy  pack  we    re    addr  cnt    pvld  pdata
        vecs[0]  = '{1'b1, 1'b1, 6'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 6'h00};
        vecs[1]  = '{1'b0, 1'b1, 6'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 5'd1, 1'b0, 6'h00};
        vecs[2]  = '{1'b0, 1'b1, 6'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 5'd2, 1'b0, 6'h00};
        vecs[3]  = '{1'b0, 1'b1, 6'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 5'd3, 1'b0, 6'h00};
        vecs[4]  = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 5'd3, 1'b0, 6'h00};
        vecs[5]  = '{1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 5'd2, 1'b1, 6'h11};
        vecs[6]  = '{1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 5'd1, 1'b1, 6'h22};
        vecs[7]  = '{1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 5'd0, 1'b1, 6'h33};
        vecs[8]  = '{1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 5'd0, 1'b0, 6'h00};
        vecs[9]  = '{1'b0, 1'b1, 6'h2A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 5'd1, 1'b0, 6'h00};
        vecs[10] = '{1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 5'd0, 1'b1, 6'h2A};
        vecs[11] = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 5'd0, 1'b0, 6'h00};

        repeat (2) tick();

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst, vecs[i].pv, vecs[i].pd, vecs[i].pr);
            check_comb($sformatf("vec%0d", i), vecs[i].e_prdy, vecs[i].e_pack, vecs[i].e_we,
                       vecs[i].e_re, vecs[i].e_addr);
            if (vecs[i].e_we) chk($sformatf("vec%0d.ram_data_in", i), ram_data_in, vecs[i].pd);
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_pvld, vecs[i].e_pdata);
        end

        // Fill from wr_ptr=4 so both pointers wrap through 15 -> 0.
        for (int i = 0; i < 16; i++) begin
            exp_d = 6'((i * 7 + 5) % 64);
            drive(1'b0, 1'b1, exp_d, 1'b0);
            check_comb($sformatf("fill%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 4'((4 + i) % 16));
            tick();
            model_q.push_back(exp_d);
        end
        check_state("filled", 5'd16, 1'b0, 6'h00);

        drive(1'b0, 1'b1, 6'h3F, 1'b0);
        check_comb("push_full", 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
        tick();
        check_state("push_full", 5'd16, 1'b0, 6'h00);

        // First drain pop also offers a push while full: it must be refused.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, i == 0, 6'h3F, 1'b1);
            check_comb($sformatf("drain%0d", i), 1'b0, 1'b1, 1'b0, 1'b1, 4'((4 + i) % 16));
            tick();
            exp_d = model_q.pop_front();
            check_state($sformatf("drain%0d", i), 5'(15 - i), 1'b1, exp_d);
        end

        // Reach count=4 with a pop as the most recent grant.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 6'(i + 1), 1'b0);
            tick();
            model_q.push_back(6'(i + 1));
        end
        drive(1'b0, 1'b0, 6'h00, 1'b1);
        check_comb("pre_pop", 1'b0, 1'b1, 1'b0, 1'b1, 4'd4);
        tick();
        exp_d = model_q.pop_front();
        check_state("pre_pop", 5'd4, 1'b1, exp_d);

        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 6'(8'h30 + k), 1'b1);
            check_comb($sformatf("cont%0d", k), (k % 2) == 0, (k % 2) == 1, (k % 2) == 0,
                       (k % 2) == 1, (k % 2) == 0 ? 4'(9 + k / 2) : 4'(5 + k / 2));
            chk($sformatf("cont%0d.both_strobes", k), ram_write_en & ram_read_en, 1'b0);
            tick();
            if ((k % 2) == 0) begin
                model_q.push_back(6'(8'h30 + k));
                check_state($sformatf("cont%0d", k), 5'd5, 1'b0, 6'h00);
            end else begin
                exp_d = model_q.pop_front();
                check_state($sformatf("cont%0d", k), 5'd4, 1'b1, exp_d);
            end
        end

        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 6'h00, 1'b1);
            chk($sformatf("tail%0d.pop_ack", i), pop_ack, 1'b1);
            tick();
            exp_d = model_q.pop_front();
            check_state($sformatf("tail%0d", i), 5'(3 - i), 1'b1, exp_d);
        end

        // Refill one entry, pop it, then reset while its data is in flight.
        drive(1'b0, 1'b1, 6'h15, 1'b0);
        tick();
        drive(1'b0, 1'b0, 6'h00, 1'b1);
        chk("mid_rst.pop_ack", pop_ack, 1'b1);
        tick();
        drive(1'b1, 1'b1, 6'h2E, 1'b1);
        check_comb("in_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'd12);
        chk("in_rst.pop_valid_before_edge", pop_valid, 1'b1);
        chk("in_rst.pop_data_before_edge", pop_data, 6'h15);
        tick();
        check_state("after_rst", 5'd0, 1'b0, 6'h00);
        drive(1'b0, 1'b0, 6'h00, 1'b0);
        chk("after_rst.ram_addr", ram_addr, 4'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
